uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

UART receive controller that sequences the serial sampling datapath behind the negedge detector. It consumes the single-cycle falling-edge pulse from `negedge_detector` as a start-bit candidate. It times mid-bit sampling of the synchronized RX line, shifts in LSB-first data, and checks the stop bit. It sits between the RX line conditioning (synchronizer plus negedge detector) and the byte consumer.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Must be even and ≥ 4.
- `DATA_BITS`, default 8: data bits per frame, range 5–8.

Ports:
- `rx_clk`, input, 1: the block's single clock.
- `rx_rst_n`, input, 1: reset, asynchronous, active-low.
- `rx_in`, input, 1: RX line, already synchronized to `rx_clk`; idle level is 1.
- `rx_negedge`, input, 1: one-cycle pulse from `negedge_detector` marking a 1→0 transition on `rx_in`.
- `rx_data`, output, DATA_BITS: last correctly framed byte, LSB = first received bit.
- `rx_valid`, output, 1: one-cycle pulse; `rx_data` was updated.
- `rx_frame_err`, output, 1: one-cycle pulse; stop bit was sampled as 0.
- `rx_busy`, output, 1: high while a frame is in progress (any state other than IDLE).

## Operation
FSM states: IDLE, START, DATA, STOP.

Shared resources:
- Bit counter `cnt`, width $clog2(CLKS_PER_BIT), cleared on every state entry and after every sample.
- Bit index `idx`, width $clog2(DATA_BITS+1).
- Shift register `sh`.

Transitions:
- **IDLE:** `rx_negedge`=1 → START, `cnt`←0. All other inputs are ignored.
- **START:** increment `cnt`. When `cnt`==CLKS_PER_BIT/2−1, sample `rx_in`:
  - 0 → DATA, `idx`←0.
  - 1 → IDLE (glitch rejected). No `rx_valid`, no `rx_frame_err`.
- **DATA:** increment `cnt`. When `cnt`==CLKS_PER_BIT−1:
  - Sample: `sh`←{`rx_in`, `sh`[DATA_BITS−1:1]}, `idx`++.
  - After the DATA_BITS-th sample → STOP.
- **STOP:** increment `cnt`. When `cnt`==CLKS_PER_BIT−1, sample `rx_in`:
  - 1 → `rx_data`←`sh`, `rx_valid` pulse.
  - 0 → `rx_frame_err` pulse; `rx_data` unchanged.
  - Either case → IDLE.

Rules:
- `rx_negedge` pulses in START/DATA/STOP are ignored (falling edges inside data bits).
- `rx_valid` and `rx_frame_err` are never high in the same cycle.
- Reset values: state IDLE, `cnt`=0, `idx`=0, `sh`=0, `rx_data`=0, `rx_valid`=0, `rx_frame_err`=0, `rx_busy`=0.
- Reset asserted mid-frame: immediate return to the reset values. No pulse is emitted for the partial frame.

## Timing
Edge 0 is the `rx_clk` rising edge at which `rx_negedge`=1 is captured in IDLE. Let H = CLKS_PER_BIT/2 and C = CLKS_PER_BIT.

Sample edges:
- Start-bit sample: edge H.
- Data bit i (i = 0..DATA_BITS−1): edge H + (i+1)·C.
- Stop-bit sample: edge H + (DATA_BITS+1)·C.

Output timing (all outputs registered, changing after the clock edge):
- `rx_busy` is high from after edge 0 until after the stop-sample edge.
- `rx_valid` or `rx_frame_err` is high for exactly the one cycle after the stop-sample edge. `rx_data` is valid from that cycle onward.
- Defaults C=16, DATA_BITS=8: start sample at edge 8, data bits at edges 24, 40, …, 136, stop sample at edge 152; pulse in the cycle after edge 152.
- Back-to-back frames: the FSM is in IDLE during the `rx_valid` cycle. A `rx_negedge` captured in that cycle starts the next frame with no lost cycles.
- Glitch abort: the FSM is back in IDLE after edge H and accepts a new `rx_negedge` from edge H+1.

## Test plan
All scenarios use C=16, DATA_BITS=8, and an `rx_in` bit period of 16 cycles with `rx_negedge` driven by `negedge_detector`.

- **Nominal frame:** send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) → `rx_data`=0xA5, a single `rx_valid` pulse in the cycle after edge 152, `rx_frame_err` stays 0, `rx_busy` high for edges 1–152.
- **Glitch rejection:** `rx_in` low for 3 cycles and then high → `rx_busy` drops after edge 8, no `rx_valid`/`rx_frame_err`, `rx_data` unchanged (0 after reset).
- **Framing error:** after receiving 0x3C, send 0x81 with stop bit 0 → `rx_frame_err` single pulse, `rx_valid`=0, `rx_data` stays 0x3C.
- **Internal edges ignored:** send 0x55 (many 1→0 transitions mid-frame) → exactly one `rx_valid`, `rx_data`=0x55, and the frame is timed from the first edge only.
- **Back-to-back:** 0x00 immediately followed by 0xFF (next start bit begins right after the stop bit) → two `rx_valid` pulses 160 cycles apart, data 0x00 then 0xFF.
- **Reset mid-frame:** assert `rx_rst_n`=0 asynchronously at edge 70 of a frame → all outputs 0 at once. After release, a fresh 0xC3 frame is received correctly with no spurious pulses.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer that times mid-bit sampling, shifts data in LSB-first and checks the stop bit.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst_n,
  input  logic                 rx_in,
  input  logic                 rx_negedge,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] sh;
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      sh           <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state)
        IDLE: if (rx_negedge) begin
          state   <= START;
          cnt     <= '0;
          rx_busy <= 1'b1;
        end
        START: if (cnt == HALF) begin
          cnt <= '0;
          if (!rx_in) begin
            state <= DATA;
            idx   <= '0;
          end else begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end else cnt <= cnt + 1'b1;
        DATA: if (cnt == FULL) begin
          cnt <= '0;
          sh  <= {rx_in, sh[DATA_BITS-1:1]};
          idx <= idx + 1'b1;
          if (idx == LAST) state <= STOP;
        end else cnt <= cnt + 1'b1;
        STOP: if (cnt == FULL) begin
          cnt     <= '0;
          state   <= IDLE;
          rx_busy <= 1'b0;
          if (rx_in) begin
            rx_data  <= sh;
            rx_valid <= 1'b1;
          end else rx_frame_err <= 1'b1;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frame vectors plus glitch and mid-frame reset sequences for uart_rx_ctrl.
module tb_uart_rx_ctrl;
  logic       rx_clk = 1'b0;
  logic       rx_rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       rx_negedge;
  logic       prev;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_busy;
  int         cyc = 0, total = 0, passed = 0;
  int         valid_cnt = 0, err_cnt = 0, busy_cnt = 0;
  int         last_valid_cyc = 0, last_err_cyc = 0;
  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         gap;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs[6];
  uart_rx_ctrl #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_in(rx_in), .rx_negedge(rx_negedge),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );
  always #5 rx_clk = ~rx_clk;
  always @(posedge rx_clk) cyc <= cyc + 1;
  // Behavioural negedge_detector feeding the DUT.
  always @(posedge rx_clk or negedge rx_rst_n) prev <= !rx_rst_n ? 1'b1 : rx_in;
  assign rx_negedge = prev & ~rx_in;
  always @(negedge rx_clk) begin
    if (rx_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    if (rx_frame_err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (rx_busy) busy_cnt++;
  end
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  task automatic drive(input logic [9:0] bits, input int n);
    for (int j = 0; j < n; j++) begin
      rx_in = bits[j/16];
      @(posedge rx_clk);
      #1;
    end
    rx_in = 1'b1;
  endtask
  task automatic run_frame(input vec_t v, input string tag);
    int v0, e0, b0, e0cyc, pv;
    v0 = valid_cnt;
    e0 = err_cnt;
    pv = last_valid_cyc;
    repeat (v.gap) begin
      @(posedge rx_clk);
      #1;
    end
    b0 = busy_cnt;
    e0cyc = cyc + 1;
    drive({v.stop, v.d, 1'b0}, 160);
    chk({tag, " valid_count"}, valid_cnt - v0, v.exp_valid);
    chk({tag, " err_count"}, err_cnt - e0, v.exp_err);
    chk({tag, " data"}, int'(rx_data), int'(v.exp_data));
    chk({tag, " busy_cycles"}, busy_cnt - b0, 152);
    if (v.exp_valid == 1) chk({tag, " valid_latency"}, last_valid_cyc - e0cyc, 152);
    if (v.exp_err == 1) chk({tag, " err_latency"}, last_err_cyc - e0cyc, 152);
    if (v.gap == 0 && v.exp_valid == 1) chk({tag, " b2b_spacing"}, last_valid_cyc - pv, 160);
  endtask
  initial begin
    int b0, v0, e0;
    vecs[0] = '{8'hA5, 1'b1, 4, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 4, 1, 0, 8'h3C};
    vecs[2] = '{8'h81, 1'b0, 4, 0, 1, 8'h3C};
    vecs[3] = '{8'h55, 1'b1, 20, 1, 0, 8'h55};
    vecs[4] = '{8'h00, 1'b1, 4, 1, 0, 8'h00};
    vecs[5] = '{8'hFF, 1'b1, 0, 1, 0, 8'hFF};
    repeat (3) @(posedge rx_clk);
    #1;
    chk("reset data", int'(rx_data), 0);
    chk("reset flags", {rx_valid, rx_frame_err, rx_busy}, 0);
    @(negedge rx_clk);
    rx_rst_n = 1'b1;
    repeat (3) @(posedge rx_clk);
    #1;
    // Glitch: line low for 3 cycles only.
    v0 = valid_cnt;
    e0 = err_cnt;
    b0 = busy_cnt;
    rx_in = 1'b0;
    repeat (3) @(posedge rx_clk);
    #1;
    rx_in = 1'b1;
    repeat (20) @(posedge rx_clk);
    #1;
    chk("glitch busy_cycles", busy_cnt - b0, 8);
    chk("glitch pulses", (valid_cnt - v0) + (err_cnt - e0), 0);
    chk("glitch data", int'(rx_data), 0);
    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));
    repeat (4) @(posedge rx_clk);
    #1;
    // Asynchronous reset between edges 70 and 71 of a 0xC3 frame.
    drive(10'b1_11000011_0, 70);
    @(posedge rx_clk);
    #2;
    rx_rst_n = 1'b0;
    #1;
    chk("midreset data", int'(rx_data), 0);
    chk("midreset flags", {rx_valid, rx_frame_err, rx_busy}, 0);
    v0 = valid_cnt;
    e0 = err_cnt;
    repeat (4) @(posedge rx_clk);
    @(negedge rx_clk);
    rx_rst_n = 1'b1;
    repeat (200) @(posedge rx_clk);
    #1;
    chk("midreset no_pulse", (valid_cnt - v0) + (err_cnt - e0), 0);
    run_frame('{8'hC3, 1'b1, 2, 1, 0, 8'hC3}, "after_reset");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
